// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock synchronous FIFO with configurable width and
// depth. It provides an occupancy count, almost-full and almost-empty
// thresholds, overflow and underflow pulses, and a synchronous flush.
// Optional build macro FIFO_FWFT_EN selects first-word-fall-through reads.
// Without FIFO_FWFT_EN, reads are registered with one cycle of latency.
`timescale 1ns/1ps

module fifo_sync_param #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_THRESH  = FIFO_DEPTH - 2,
  parameter int unsigned AE_THRESH  = 2,
  localparam int unsigned ADDR_W    = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0]  AE_C    = CNT_W'(AE_THRESH);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  // Storage array; contents are deliberately left unreset.
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [ADDR_W-1:0] wr_ptr, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_acc, rd_acc;
  logic              mem_we;

  // Flags are decoded straight from the registered count so they are never stale.
  assign full         = (cnt_q == DEPTH_C);
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= AF_C);
  assign almost_empty = (cnt_q <= AE_C);
  assign count        = cnt_q;

  // Acceptance is judged on pre-edge occupancy; a flush suppresses both sides.
  assign wr_acc = wr_en && !full  && !clr;
  assign rd_acc = rd_en && !empty && !clr;
  assign mem_we = wr_acc;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= data_in;
  end

  // One-cycle error pulses for rejected requests; a flush masks them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full  && !clr;
      underflow <= rd_en && empty && !clr;
    end
  end

`ifdef FIFO_FWFT_EN
  // The head word is presented combinationally while the FIFO holds data.
  assign data_out = mem[rd_ptr];
  assign rd_valid = !empty;
`else
  // Registered read: each popped word is captured and rd_valid pulses for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else if (clr) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed and scoreboarded checks for fifo_sync_param.
// The bench uses DATA_WIDTH=8 and FIFO_DEPTH=16. It tests the registered
// build, or the FWFT build when FIFO_FWFT_EN is defined.
`timescale 1ns/1ps

module tb_fifo_sync_param;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clr;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic          full, empty, almost_full, almost_empty;
  logic [4:0]    count;
  logic          overflow, underflow;

  int n_vec = 0;
  int n_err = 0;

  fifo_sync_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(14), .AE_THRESH(2)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_d;
  logic          w, r, wa, ra, eov, eun;

  initial begin
    reset_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    #23;
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow), 0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef FIFO_FWFT_EN
    wr_en = 1'b1; data_in = 8'hA5;
    tick();
    chk("fwft_data", 32'(data_out), 32'hA5);
    chk("fwft_valid", 32'(rd_valid), 1);
    data_in = 8'h5A;
    tick();
    chk("fwft_hold", 32'(data_out), 32'hA5);
    chk("fwft_count2", 32'(count), 2);
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    chk("fwft_next", 32'(data_out), 32'h5A);
    chk("fwft_count1", 32'(count), 1);
    tick();
    chk("fwft_empty", 32'(empty), 1);
    chk("fwft_valid0", 32'(rd_valid), 0);
    tick();
    chk("fwft_underflow", 32'(underflow), 1);
    idle();
    tick();
    chk("fwft_underflow0", 32'(underflow), 0);
`else
    // Fill 0x00..0x0F and check the flags after every edge.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; data_in = DW'(i);
      tick();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 14));
      chk("fill_full", 32'(full), 32'((i + 1) == 16));
      chk("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 2));
    end
    data_in = 8'h55;
    tick();
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 16);
    idle();
    tick();
    chk("ovf_clear", 32'(overflow), 0);

    // Drain in order.
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain_data", 32'(data_out), 32'(i));
      chk("drain_valid", 32'(rd_valid), 1);
      chk("drain_count", 32'(count), 32'(15 - i));
    end
    chk("drain_empty", 32'(empty), 1);
    tick();
    chk("unf_pulse", 32'(underflow), 1);
    chk("unf_hold", 32'(data_out), 32'h0F);
    chk("unf_valid", 32'(rd_valid), 0);
    idle();
    tick();
    chk("unf_clear", 32'(underflow), 0);

    // Full with simultaneous write and read.
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; data_in = DW'(8'h20 + i);
      tick();
    end
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h99;
    tick();
    chk("fwr_count", 32'(count), 15);
    chk("fwr_overflow", 32'(overflow), 1);
    chk("fwr_data", 32'(data_out), 32'h20);
    chk("fwr_valid", 32'(rd_valid), 1);
    idle(); clr = 1'b1;
    tick();
    chk("clr_count", 32'(count), 0);
    chk("clr_overflow", 32'(overflow), 0);

    // Empty with simultaneous write and read.
    clr = 1'b0; wr_en = 1'b1; rd_en = 1'b1; data_in = 8'h77;
    tick();
    chk("ewr_count", 32'(count), 1);
    chk("ewr_underflow", 32'(underflow), 1);
    chk("ewr_valid", 32'(rd_valid), 0);
    chk("ewr_data_hold", 32'(data_out), 32'h20);
    idle();
    tick();
    chk("ewr_unf_clear", 32'(underflow), 0);

    // Flush at count 9 with both requests asserted.
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; data_in = DW'(8'h30 + i);
      tick();
    end
    chk("pre_clr_count", 32'(count), 9);
    clr = 1'b1; wr_en = 1'b1; rd_en = 1'b1;
    tick();
    chk("clr9_count", 32'(count), 0);
    chk("clr9_empty", 32'(empty), 1);
    chk("clr9_overflow", 32'(overflow), 0);
    chk("clr9_underflow", 32'(underflow), 0);
    chk("clr9_valid", 32'(rd_valid), 0);
    chk("clr9_data_hold", 32'(data_out), 32'h20);
    idle();

    // Random interleaving against a queue model.
    for (int c = 0; c < 200; c++) begin
      w = (c < 100) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      r = (c < 100) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
      eov = w && (q.size() == DEPTH);
      eun = r && (q.size() == 0);
      wa  = w && (q.size() != DEPTH);
      ra  = r && (q.size() != 0);
      wr_en = w; rd_en = r; data_in = DW'($urandom);
      if (ra) exp_d = q.pop_front();
      if (wa) q.push_back(data_in);
      tick();
      chk("rnd_count", 32'(count), 32'(q.size()));
      chk("rnd_valid", 32'(rd_valid), 32'(ra));
      chk("rnd_overflow", 32'(overflow), 32'(eov));
      chk("rnd_underflow", 32'(underflow), 32'(eun));
      if (ra) chk("rnd_data", 32'(data_out), 32'(exp_d));
    end
    idle();

    // Asynchronous reset mid-burst, between clock edges.
    wr_en = 1'b1; data_in = 8'hE1;
    tick();
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_data", 32'(data_out), 0);
    chk("arst_valid", 32'(rd_valid), 0);
    idle();
    @(negedge clk);
    reset_n = 1'b1;
    wr_en = 1'b1; data_in = 8'hC3;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    chk("post_rst_data", 32'(data_out), 32'hC3);
    chk("post_rst_count", 32'(count), 0);
    idle();
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
